// File: rtl/ro_pair_freq_cmp.sv
// Ring-oscillator pair frequency comparator: gates both oscillators over a
// fixed clk window, counts their synchronized rising edges and emits one PUF bit.
module ro_pair_freq_cmp #(
    parameter int CNT_W       = 16,
    parameter int WINDOW      = 64,
    parameter int SETTLE      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ro_a,
    input  logic             ro_b,
    output logic             osc_en,
    output logic             busy,
    output logic             done,
    output logic             response,
    output logic             tie,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b
);

    localparam int TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_CMP,
        ST_DONE
    } state_t;

    state_t                 state, state_nx;
    logic [TW-1:0]          timer;
    logic [SYNC_STAGES-1:0] sync_a, sync_b;
    logic                   hist_a, hist_b;
    logic                   rise_a, rise_b;
    logic                   settle_last, window_last;

    // Synchronizers and edge history run regardless of state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
            hist_a <= 1'b0;
            hist_b <= 1'b0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], ro_a};
            sync_b <= {sync_b[SYNC_STAGES-2:0], ro_b};
            hist_a <= sync_a[SYNC_STAGES-1];
            hist_b <= sync_b[SYNC_STAGES-1];
        end
    end

    assign rise_a      = sync_a[SYNC_STAGES-1] & ~hist_a;
    assign rise_b      = sync_b[SYNC_STAGES-1] & ~hist_b;
    assign settle_last = (timer == TW'(SETTLE - 1));
    assign window_last = (timer == TW'(WINDOW - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:    if (start) state_nx = ST_SETTLE;
            ST_SETTLE:  if (settle_last) state_nx = ST_MEASURE;
            ST_MEASURE: if (window_last) state_nx = ST_CMP;
            ST_CMP:     state_nx = ST_DONE;
            ST_DONE:    state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        osc_en = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (state)
            ST_SETTLE, ST_MEASURE, ST_CMP: begin
                osc_en = 1'b1;
                busy   = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Timer restarts on every state change, so it counts cycles spent in the current state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (state_nx != state || state == ST_IDLE) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_a  <= '0;
            count_b  <= '0;
            response <= 1'b0;
            tie      <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                count_a <= '0;
                count_b <= '0;
            end else if (state == ST_MEASURE && !window_last) begin
                if (rise_a && count_a != '1) count_a <= count_a + CNT_W'(1);
                if (rise_b && count_b != '1) count_b <= count_b + CNT_W'(1);
            end
            if (state == ST_CMP) begin
                response <= (count_a > count_b);
                tie      <= (count_a == count_b);
            end
        end
    end

endmodule

// File: tb/tb_ro_pair_freq_cmp.sv
// Scoreboard bench for ro_pair_freq_cmp: oscillators are modelled as periodic
// sample streams and expected counts come from counting edges in the gate window.
module tb_ro_pair_freq_cmp;

    localparam int S       = 4;
    localparam int W0      = 48;
    localparam int W1      = 32;
    localparam int CW0     = 16;
    localparam int CW1     = 3;
    localparam int SS      = 2;

    typedef struct {
        int done_edge;
        int ca;
        int cb;
        bit resp;
        bit tie;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0;
    logic ro_a = 1'b0, ro_b = 1'b0;

    logic            osc_en0, busy0, done0, resp0, tie0;
    logic [CW0-1:0]  ca0, cb0;
    logic            osc_en1, busy1, done1, resp1, tie1;
    logic [CW1-1:0]  ca1, cb1;

    int tests = 0;
    int fails = 0;
    int ncyc  = 0;
    int pa = 4, ha = 2, pha = 0;
    int pb = 6, hb = 3, phb = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t last0;

    ro_pair_freq_cmp #(.CNT_W(CW0), .WINDOW(W0), .SETTLE(S), .SYNC_STAGES(SS)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .ro_a(ro_a), .ro_b(ro_b),
        .osc_en(osc_en0), .busy(busy0), .done(done0), .response(resp0), .tie(tie0),
        .count_a(ca0), .count_b(cb0)
    );

    ro_pair_freq_cmp #(.CNT_W(CW1), .WINDOW(W1), .SETTLE(S), .SYNC_STAGES(SS)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .ro_a(ro_a), .ro_b(ro_b),
        .osc_en(osc_en1), .busy(busy1), .done(done1), .response(resp1), .tie(tie1),
        .count_a(ca1), .count_b(cb1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ncyc++;

    function automatic bit wave(int k, int p, int h, int ph);
        return ((k + ph) % p) < h;
    endfunction

    // Value presented before edge k is wave(k); set on the preceding falling edge.
    always @(negedge clk) begin
        ro_a = wave(ncyc, pa, ha, pha);
        ro_b = wave(ncyc, pb, hb, phb);
    end

    // Edge counted at clk edge j+1 when the sample stream, delayed by the
    // synchronizer, rose between samples j-SS and j-SS+1 within the gate.
    function automatic exp_t model(int e0, int w, int cw);
        exp_t e;
        int   na = 0, nb = 0, sat;
        for (int j = e0 + S; j <= e0 + S + w - 2; j++) begin
            if (wave(j-SS+1, pa, ha, pha) && !wave(j-SS, pa, ha, pha)) na++;
            if (wave(j-SS+1, pb, hb, phb) && !wave(j-SS, pb, hb, phb)) nb++;
        end
        sat = (1 << cw) - 1;
        e.ca = (na > sat) ? sat : na;
        e.cb = (nb > sat) ? sat : nb;
        e.resp = e.ca > e.cb;
        e.tie = e.ca == e.cb;
        e.done_edge = e0 + S + w + 1;
        return e;
    endfunction

    task automatic chk(input string nm, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done0) begin
            if (q0.size() == 0) begin
                chk("unexpected_done0", 1, 0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("latency0", ncyc - 1, e.done_edge);
                chk("count_a0", ca0, e.ca);
                chk("count_b0", cb0, e.cb);
                chk("response0", resp0, e.resp);
                chk("tie0", tie0, e.tie);
                chk("busy_at_done0", busy0, 0);
                chk("osc_en_at_done0", osc_en0, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (done1) begin
            if (q1.size() == 0) begin
                chk("unexpected_done1", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("latency1", ncyc - 1, e.done_edge);
                chk("count_a1", ca1, e.ca);
                chk("count_b1", cb1, e.cb);
                chk("response1", resp1, e.resp);
                chk("tie1", tie1, e.tie);
            end
        end
    end

    task automatic set_waves(input int a_p, input int a_h, input int a_ph,
                             input int b_p, input int b_h, input int b_ph);
        pa = a_p; ha = a_h; pha = a_ph;
        pb = b_p; hb = b_h; phb = b_ph;
        @(negedge clk);
    endtask

    task automatic drain(input int unit_sel);
        int n = 0;
        while (((unit_sel == 0) ? q0.size() : q1.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("drain_timeout", n, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic launch0(input bit push);
        int e0;
        @(negedge clk);
        start0 = 1'b1;
        e0 = ncyc;
        if (push) begin
            last0 = model(e0, W0, CW0);
            q0.push_back(last0);
        end
        @(negedge clk);
        start0 = 1'b0;
        chk("osc_en_after_start", osc_en0, 1);
        chk("busy_after_start", busy0, 1);
    endtask

    task automatic run1();
        int e0;
        @(negedge clk);
        start1 = 1'b1;
        e0 = ncyc;
        q1.push_back(model(e0, W1, CW1));
        @(negedge clk);
        start1 = 1'b0;
        drain(1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

    initial begin
        int e0;
        rst = 1'b1;
        start0 = 1'b1;
        start1 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_osc_en", osc_en0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_resp", resp0, 0);
        chk("rst_tie", tie0, 0);
        chk("rst_counts", {ca0, cb0}, 0);
        start0 = 1'b0;
        start1 = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", busy0 | osc_en0 | busy1, 0);

        // A faster than B
        set_waves(4, 2, 0, 6, 3, 1);
        launch0(1);
        drain(0);
        // B faster than A
        set_waves(6, 3, 2, 4, 2, 0);
        launch0(1);
        drain(0);
        // identical waves tie
        set_waves(4, 2, 1, 4, 2, 1);
        launch0(1);
        drain(0);
        chk("tie_flag", tie0, 1);

        // saturation on the narrow counter
        set_waves(2, 1, 0, 2, 1, 1);
        run1();
        chk("sat_a", ca1, 7);

        // start while busy is ignored; outputs then hold while inputs toggle
        set_waves(5, 2, 0, 7, 3, 2);
        launch0(1);
        repeat (8) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        drain(0);
        repeat (20) @(negedge clk);
        chk("hold_count_a", ca0, last0.ca);
        chk("hold_count_b", cb0, last0.cb);
        chk("hold_resp", resp0, last0.resp);
        chk("hold_done_low", done0, 0);

        // start held high restarts back to back
        set_waves(3, 1, 0, 5, 2, 0);
        start0 = 1'b1;
        e0 = ncyc;
        q0.push_back(model(e0, W0, CW0));
        q0.push_back(model(e0 + S + W0 + 3, W0, CW0));
        while (ncyc < e0 + S + W0 + 4) @(negedge clk);
        start0 = 1'b0;
        drain(0);

        // reset in the middle of a measurement
        set_waves(4, 2, 0, 6, 3, 0);
        launch0(0);
        repeat (20) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_osc_en", osc_en0, 0);
        chk("midrst_busy", busy0, 0);
        chk("midrst_counts", {ca0, cb0}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        launch0(1);
        drain(0);

        for (int i = 0; i < 8; i++) begin
            int p1, p2;
            p1 = $urandom_range(2, 9);
            p2 = $urandom_range(2, 9);
            set_waves(p1, $urandom_range(1, p1 - 1), $urandom_range(0, p1 - 1),
                      p2, $urandom_range(1, p2 - 1), $urandom_range(0, p2 - 1));
            launch0(1);
            drain(0);
        end
        for (int i = 0; i < 3; i++) begin
            int p1, p2;
            p1 = $urandom_range(2, 6);
            p2 = $urandom_range(2, 6);
            set_waves(p1, $urandom_range(1, p1 - 1), $urandom_range(0, p1 - 1),
                      p2, $urandom_range(1, p2 - 1), $urandom_range(0, p2 - 1));
            run1();
        end

        chk("queue0_empty", q0.size(), 0);
        chk("queue1_empty", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ro_pair_freq_cmp.md
Name: ro_pair_freq_cmp

Overview:
- Downstream stage of the ring-oscillator instances.
- Enables a selected pair of oscillators and counts the rising edges of each over a fixed clk-cycle gate window.
- Compares the two counts and emits one PUF response bit, plus the raw counts and a tie flag.
- Sits between the oscillator array (fed through osc_en) and the response-collection logic.

Parameters:
- CNT_W, 16, width of each edge counter and count output.
- WINDOW, 64, gate length in clk cycles (>=1).
- SETTLE, 4, clk cycles between enabling the oscillators and opening the gate (>=SYNC_STAGES+1).
- SYNC_STAGES, 2, synchronizer flops per oscillator input (>=2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  one-cycle request to run a measurement; sampled only in IDLE.
- ro_a  input  1  output of oscillator A (asynchronous to clk).
- ro_b  input  1  output of oscillator B (asynchronous to clk).
- osc_en  output  1  enable for both oscillators.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; response and counts are valid.
- response  output  1  1 if count_a > count_b, else 0.
- tie  output  1  1 if count_a == count_b.
- count_a  output  CNT_W  rising edges of ro_a seen in the gate.
- count_b  output  CNT_W  rising edges of ro_b seen in the gate.

Behaviour:
- Reset (async assert, sync release): state IDLE. osc_en, busy, done, response and tie are 0. count_a, count_b, synchronizer flops and edge-history flops are 0.
- Input conditioning:
  - Each ro_x passes through SYNC_STAGES flops, then one history flop.
  - rise_x = sync_x & ~hist_x.
  - Synchronizers run in every state.
- States and transitions:
  - IDLE: start=1 -> SETTLE. In the same edge, clear both counters and the settle/gate timer, and set osc_en=1, busy=1.
  - SETTLE: counters do not count. After exactly SETTLE cycles in this state -> MEASURE, with the timer cleared.
  - MEASURE:
    - Each cycle, count_x increments by 1 when rise_x=1.
    - Counters saturate at 2^CNT_W-1 and never wrap.
    - After exactly WINDOW cycles in this state -> CMP.
    - Edges seen in the cycle of the transition are not counted.
  - CMP (1 cycle):
    - response <= (count_a > count_b), unsigned compare.
    - tie <= (count_a == count_b); a tie gives response=0.
    - osc_en <= 0.
    - Next state DONE.
  - DONE (1 cycle): done=1, busy=0 at the output edge entering IDLE, then the state is IDLE.
- Timing:
  - Latency from the start cycle to the done pulse is SETTLE+WINDOW+2 cycles.
  - busy is high for SETTLE+WINDOW+1 cycles.
- Hold rules:
  - response, tie, count_a and count_b hold their values after done until the next accepted start.
  - On the next accepted start, count_a and count_b clear and response/tie keep their old values until CMP.
- start behaviour:
  - start while busy, or in the DONE cycle, is ignored (no queueing).
  - start held high continuously restarts a measurement each time IDLE is reached.
- rst asserted mid-measurement: immediate return to reset values, osc_en drops asynchronously, and no done pulse is issued.
- Both counters can increment in the same cycle; they are independent.

Test Plan:
- Reset check: assert rst for 2 cycles with ro_a/ro_b toggling -> osc_en=0, busy=0, done=0, response=0, tie=0, counts=0; start during rst has no effect.
- Faster A: ro_a has period 4 clk, ro_b has period 6 clk, WINDOW=48, SETTLE=4; pulse start -> osc_en=1 next cycle, done exactly 54 cycles after start. count_a=12±1, count_b=8±1, response=1, tie=0.
- Faster B: swap the periods (A=6, B=4) -> response=0, tie=0, count_b > count_a.
- Tie and saturation:
  - Tie: both inputs period 4, same phase -> count_a==count_b=12, tie=1, response=0.
  - Saturation: CNT_W=3, period 2, WINDOW=32 -> counts hold at 7, no wrap.
- start while busy and holding: pulse start at cycle 10 of a run -> no effect, a single done pulse only. After done, counts and response hold for 20 idle cycles while the ro_x inputs keep toggling.
- Mid-run reset: assert rst during MEASURE -> osc_en falls without a clk edge, counts=0, no done. A start after rst deasserts -> a full normal run with correct latency.
